// File: rtl/bram_dot_product_engine.sv
// bram_dot_product_engine: streams an int8x4 input vector and weight vector
// out of BRAM port B, accumulates their dot product and writes the 32-bit
// signed result back to the same BRAM.
// Optional feature macro: DOT_RELU_EN (clamp negative results to zero).

// Signed 8x8 -> 16 lane multiplier; both operands sign-extended first.
module dpe_lane_mul (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  assign p_o = $signed({{8{a_i[7]}}, a_i}) * $signed({{8{b_i[7]}}, b_i});
endmodule

module bram_dot_product_engine #(
  parameter int READ_LATENCY = 2
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_areset,
  input  logic        start,
  input  logic [9:0]  in_base,
  input  logic [9:0]  w_base,
  input  logic [9:0]  out_addr,
  input  logic [10:0] num_words,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [9:0]  BRAM_PORTB_addr,
  output logic [31:0] BRAM_PORTB_din,
  input  logic [31:0] BRAM_PORTB_dout,
  output logic        BRAM_PORTB_en,
  output logic        BRAM_PORTB_rst,
  output logic [3:0]  BRAM_PORTB_we
);
  localparam int LANES = 4;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  state_t state_q, state_d;

  logic [9:0]  in_base_q, w_base_q, out_addr_q;
  logic [10:0] nw_q, k_q;
  logic        phase_q;                 // 0: input word next, 1: weight word next
  logic [READ_LATENCY-1:0] tag_v_q;     // read in flight at this pipeline depth
  logic [READ_LATENCY-1:0] tag_w_q;     // that read is a weight word
  logic [31:0] x_q, acc_q, result_q;

  logic        issue, last_issue, lower_busy, drain_done;
  logic [LANES-1:0][15:0] prod;
  logic [17:0] lane_sum;
  logic [31:0] final_val;

  assign issue      = (state_q == ISSUE);
  assign last_issue = issue && phase_q && (k_q == nw_q - 11'd1);

  // Final W return: the oldest tag is a weight and nothing younger is pending.
  always_comb begin
    lower_busy = 1'b0;
    for (int i = 0; i < READ_LATENCY - 1; i++) lower_busy = lower_busy | tag_v_q[i];
  end
  assign drain_done = tag_v_q[READ_LATENCY-1] && tag_w_q[READ_LATENCY-1] && !lower_busy;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dpe_lane_mul u_mul (
      .a_i (x_q[8*i +: 8]),
      .b_i (BRAM_PORTB_dout[8*i +: 8]),
      .p_o (prod[i])
    );
  end

  // Sum of the four signed lane products, sign-extended to 18 bits each.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + {{2{prod[i][15]}}, prod[i]};
  end

`ifdef DOT_RELU_EN
  assign final_val = acc_q[31] ? 32'd0 : acc_q;
`else
  assign final_val = acc_q;
`endif

  // State register.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_words == 11'd0) ? WRITE : ISSUE;
      ISSUE:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch and read-issue counters.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      in_base_q  <= '0;
      w_base_q   <= '0;
      out_addr_q <= '0;
      nw_q       <= '0;
      k_q        <= '0;
      phase_q    <= 1'b0;
    end else if (state_q == IDLE && start) begin
      in_base_q  <= in_base;
      w_base_q   <= w_base;
      out_addr_q <= out_addr;
      nw_q       <= num_words;
      k_q        <= '0;
      phase_q    <= 1'b0;
    end else if (issue) begin
      phase_q <= ~phase_q;
      if (phase_q) k_q <= k_q + 11'd1;
    end
  end

  // Tag shift register tracking which returning word is X or W.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      tag_v_q <= '0;
      tag_w_q <= '0;
    end else begin
      tag_v_q[0] <= issue;
      tag_w_q[0] <= phase_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_w_q[i] <= tag_w_q[i-1];
      end
    end
  end

  // Operand capture and accumulate on returning read data.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      x_q   <= '0;
      acc_q <= '0;
    end else if (state_q == IDLE && start) begin
      acc_q <= '0;
    end else if (tag_v_q[READ_LATENCY-1]) begin
      if (tag_w_q[READ_LATENCY-1]) acc_q <= acc_q + {{14{lane_sum[17]}}, lane_sum};
      else                         x_q   <= BRAM_PORTB_dout;
    end
  end

  // Result register follows the written value.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset)          result_q <= '0;
    else if (state_q == WRITE) result_q <= final_val;
  end

  // Port B drive: reads in ISSUE, single full-word write in WRITE, idle otherwise.
  always_comb begin
    BRAM_PORTB_en   = 1'b0;
    BRAM_PORTB_we   = 4'h0;
    BRAM_PORTB_addr = '0;
    BRAM_PORTB_din  = '0;
    if (issue) begin
      BRAM_PORTB_en   = 1'b1;
      BRAM_PORTB_addr = phase_q ? (w_base_q + k_q[9:0]) : (in_base_q + k_q[9:0]);
    end else if (state_q == WRITE) begin
      BRAM_PORTB_en   = 1'b1;
      BRAM_PORTB_we   = 4'hF;
      BRAM_PORTB_addr = out_addr_q;
      BRAM_PORTB_din  = final_val;
    end
  end

  assign BRAM_PORTB_rst = 1'b0;
  assign busy   = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == WRITE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_bram_dot_product_engine.sv
// Directed bench for bram_dot_product_engine with a behavioural
// READ_LATENCY=2 BRAM model on port B. Honours DOT_RELU_EN for expectations.
module tb_bram_dot_product_engine;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [9:0]  in_base, w_base, out_addr;
  logic [10:0] num_words;
  logic        busy, done;
  logic [31:0] result;
  logic [9:0]  b_addr;
  logic [31:0] b_din, b_dout;
  logic        b_en, b_rst;
  logic [3:0]  b_we;

  always #5 clk = ~clk;

  bram_dot_product_engine #(.READ_LATENCY(2)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .start(start),
    .in_base(in_base), .w_base(w_base), .out_addr(out_addr), .num_words(num_words),
    .busy(busy), .done(done), .result(result),
    .BRAM_PORTB_addr(b_addr), .BRAM_PORTB_din(b_din), .BRAM_PORTB_dout(b_dout),
    .BRAM_PORTB_en(b_en), .BRAM_PORTB_rst(b_rst), .BRAM_PORTB_we(b_we)
  );

`ifdef DOT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  // BRAM model: two-cycle read latency, backdoor load port for preloading.
  logic [31:0] mem [1024];
  logic [31:0] rd1;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (b_en && b_we == 4'hF) mem[b_addr] <= b_din;
    if (b_en) rd1 <= mem[b_addr];
    b_dout <= rd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Port B monitor, sampled on the falling edge.
  int nwr, ndone, wr_cyc, done_cyc;
  logic [9:0]  wr_addr;
  logic [31:0] wr_din;
  logic [9:0]  rd_q[$];
  always @(negedge clk) begin
    if (b_en && b_we == 4'h0) rd_q.push_back(b_addr);
    if (b_we != 4'h0) begin nwr++; wr_cyc = cyc; wr_addr = b_addr; wr_din = b_din; end
    if (done) begin ndone++; done_cyc = cyc; end
  end

  int errors = 0, checks = 0;
  int c0;
  bit tmo;

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Issue one command at the current falling edge; returns one cycle after done.
  task automatic run_cmd(input logic [9:0] ib, input logic [9:0] wb, input logic [9:0] oa,
                         input logic [10:0] n, input int busy_start);
    in_base = ib; w_base = wb; out_addr = oa; num_words = n; start = 1'b1;
    nwr = 0; ndone = 0; rd_q.delete(); c0 = cyc; tmo = 1'b0;
    @(negedge clk);
    for (int t = 0; !done; t++) begin
      if (t > 4000) begin tmo = 1'b1; break; end
      start = (busy_start > 0) && (cyc == c0 + busy_start);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    checks++; if (tmo) begin errors++; $display("FAIL timeout: no done pulse within 4000 cycles"); end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_base = '0; w_base = '0; out_addr = '0; num_words = '0;
    repeat (3) @(negedge clk);
    checks++; if (b_en !== 1'b0)   begin errors++; $display("FAIL rst_en: got %b expected 0", b_en); end
    checks++; if (b_we !== 4'h0)   begin errors++; $display("FAIL rst_we: got %h expected 0", b_we); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_result: got %h expected 0", result); end
    checks++; if (b_rst !== 1'b0)  begin errors++; $display("FAIL rst_portb_rst: got %b expected 0", b_rst); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // 1*1 + 2*1 + 3*1 + 4*1 = 10
  task automatic test_single;
    load(10'h010, 32'h01020304);
    load(10'h020, 32'h01010101);
    run_cmd(10'h010, 10'h020, 10'h3FF, 11'd1, 0);
    checks++; if (nwr !== 1)            begin errors++; $display("FAIL single_nwr: got %0d expected 1", nwr); end
    checks++; if (wr_addr !== 10'h3FF)  begin errors++; $display("FAIL single_waddr: got %h expected 3ff", wr_addr); end
    checks++; if (wr_din !== 32'h0000000A) begin errors++; $display("FAIL single_wdata: got %h expected 0000000a", wr_din); end
    checks++; if (wr_cyc !== c0 + 5)    begin errors++; $display("FAIL single_wcyc: got C0+%0d expected C0+5", wr_cyc - c0); end
    checks++; if (done_cyc !== c0 + 6)  begin errors++; $display("FAIL single_donecyc: got C0+%0d expected C0+6", done_cyc - c0); end
    checks++; if (result !== 32'h0000000A) begin errors++; $display("FAIL single_result: got %h expected 0000000a", result); end
    checks++; if (mem[10'h3FF] !== 32'h0000000A) begin errors++; $display("FAIL single_mem: got %h expected 0000000a", mem[10'h3FF]); end
    checks++; if (rd_q.size() !== 2)    begin errors++; $display("FAIL single_nreads: got %0d expected 2", rd_q.size()); end
    else begin
      checks++; if (rd_q[0] !== 10'h010 || rd_q[1] !== 10'h020)
        begin errors++; $display("FAIL single_raddr: got %h,%h expected 010,020", rd_q[0], rd_q[1]); end
    end
  endtask

  task automatic test_reset_mid;
    in_base = 10'h040; w_base = 10'h080; out_addr = 10'h0F0; num_words = 11'd8; start = 1'b1;
    nwr = 0; ndone = 0; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; cyc != c0 + 5 && t < 20; t++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (b_en !== 1'b0)    begin errors++; $display("FAIL midrst_en: got %b expected 0", b_en); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL midrst_result: got %h expected 0", result); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (nwr !== 0)   begin errors++; $display("FAIL midrst_nowrite: got %0d writes expected 0", nwr); end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_nodone: got %0d dones expected 0", ndone); end
    run_cmd(10'h010, 10'h020, 10'h3FE, 11'd1, 0);
    checks++; if (result !== 32'h0000000A) begin errors++; $display("FAIL midrst_fresh: got %h expected 0000000a", result); end
    checks++; if (wr_cyc !== c0 + 5) begin errors++; $display("FAIL midrst_fresh_wcyc: got C0+%0d expected C0+5", wr_cyc - c0); end
  endtask

  // Lanes: (-128*127) + (-1*127) + (-128*127) + (-1*127) = -32766
  task automatic test_negative;
    logic [31:0] exp_v;
    exp_v = RELU ? 32'd0 : 32'hFFFF8002;
    load(10'h030, 32'hFF80FF80);
    load(10'h031, 32'h7F7F7F7F);
    run_cmd(10'h030, 10'h031, 10'h032, 11'd1, 0);
    checks++; if (wr_din !== exp_v) begin errors++; $display("FAIL neg_wdata: got %h expected %h", wr_din, exp_v); end
    checks++; if (result !== exp_v) begin errors++; $display("FAIL neg_result: got %h expected %h", result, exp_v); end
    checks++; if (mem[10'h032] !== exp_v) begin errors++; $display("FAIL neg_mem: got %h expected %h", mem[10'h032], exp_v); end
  endtask

  task automatic test_zero;
    load(10'h055, 32'hDEADBEEF);
    run_cmd(10'h100, 10'h200, 10'h055, 11'd0, 0);
    checks++; if (nwr !== 1 || wr_addr !== 10'h055) begin errors++; $display("FAIL zero_write: got %0d writes at %h expected 1 at 055", nwr, wr_addr); end
    checks++; if (wr_din !== 32'd0)    begin errors++; $display("FAIL zero_wdata: got %h expected 0", wr_din); end
    checks++; if (wr_cyc !== c0 + 1)   begin errors++; $display("FAIL zero_wcyc: got C0+%0d expected C0+1", wr_cyc - c0); end
    checks++; if (done_cyc !== c0 + 2) begin errors++; $display("FAIL zero_donecyc: got C0+%0d expected C0+2", done_cyc - c0); end
    checks++; if (rd_q.size() !== 0)   begin errors++; $display("FAIL zero_nreads: got %0d expected 0", rd_q.size()); end
    checks++; if (mem[10'h055] !== 32'd0) begin errors++; $display("FAIL zero_mem: got %h expected 0", mem[10'h055]); end
  endtask

  // 4 lanes of 2*3 = 24; then 4 lanes of 2*2 = 16.
  task automatic test_start_while_busy;
    load(10'h060, 32'h02020202);
    load(10'h061, 32'h03030303);
    run_cmd(10'h060, 10'h061, 10'h070, 11'd1, 3);
    checks++; if (nwr !== 1)   begin errors++; $display("FAIL busy_nwr: got %0d expected 1", nwr); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_ndone: got %0d expected 1", ndone); end
    checks++; if (done_cyc !== c0 + 6) begin errors++; $display("FAIL busy_donecyc: got C0+%0d expected C0+6", done_cyc - c0); end
    checks++; if (result !== 32'h18) begin errors++; $display("FAIL busy_result: got %h expected 00000018", result); end
    run_cmd(10'h060, 10'h060, 10'h071, 11'd1, 0);
    checks++; if (done_cyc !== c0 + 6) begin errors++; $display("FAIL b2b_donecyc: got C0+%0d expected C0+6", done_cyc - c0); end
    checks++; if (result !== 32'h10)   begin errors++; $display("FAIL b2b_result: got %h expected 00000010", result); end
  endtask

  // Both vectors span all of memory: X[k]=mem[0x200+k], W[k]=mem[k]. Every pair is
  // 0x7F-lanes against 0x80-lanes, giving -(1024*4*127*128) = 0xFC080000.
  task automatic test_full_wrap;
    logic [31:0] exp_v;
    exp_v = RELU ? 32'd0 : 32'hFC080000;
    for (int a = 0; a < 1024; a++) load(10'(a), (a >= 512) ? 32'h7F7F7F7F : 32'h80808080);
    run_cmd(10'h200, 10'h000, 10'h100, 11'd1024, 0);
    checks++; if (result !== exp_v) begin errors++; $display("FAIL full_result: got %h expected %h", result, exp_v); end
    checks++; if (rd_q.size() !== 2048) begin errors++; $display("FAIL full_nreads: got %0d expected 2048", rd_q.size()); end
    else begin
      checks++; if (rd_q[1022] !== 10'h3FF || rd_q[1024] !== 10'h000)
        begin errors++; $display("FAIL full_wrap: got %h then %h expected 3ff then 000", rd_q[1022], rd_q[1024]); end
    end
    checks++; if (wr_cyc !== c0 + 2051)   begin errors++; $display("FAIL full_wcyc: got C0+%0d expected C0+2051", wr_cyc - c0); end
    checks++; if (done_cyc !== c0 + 2052) begin errors++; $display("FAIL full_donecyc: got C0+%0d expected C0+2052", done_cyc - c0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_negative();
    test_zero();
    test_start_while_busy();
    test_full_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
